// File: rtl/axis_pkt_sink.sv
// axis_pkt_sink: AXI-Stream packet sink for the stream FIFO master port.
//
// Drives TREADY from a rotating 8-slot backpressure mask and accepts beats.
// For every packet it reports the beat count, a 16-bit data sum and an error
// flag. The report appears as a one-cycle pkt_done pulse with its values held.
//
// Optional feature (macro AXIS_SINK_PATTERN_CHK_EN): an incrementing-data
// check. Each non-first beat must equal the previous expected value + 1.
// A mismatch raises pkt_err. With the macro undefined, pkt_err reports only
// length overflow.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              sink enable; 0 drops TREADY on the next cycle
//   bp_mask[7:0]    backpressure pattern; bit i = TREADY in slot i
//   s_axis_*        AXI-Stream slave side (tvalid/tdata/tlast in, tready out)
//   pkt_done        one-cycle pulse, packet result valid
//   pkt_len         beats in completed packet, saturating at MAX_LEN
//   pkt_sum         sum of accepted tdata, modulo 2^16
//   pkt_err         length (or pattern) error in completed packet
//   pkt_count       completed packets since reset, wrapping
module axis_pkt_sink #(
   parameter int  WIDTH   = 8,
   parameter int  MAX_LEN = 256,
   localparam int LW      = $clog2(MAX_LEN) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [7:0]       bp_mask,
   input  logic             s_axis_tvalid,
   input  logic [WIDTH-1:0] s_axis_tdata,
   input  logic             s_axis_tlast,
   output logic             s_axis_tready,
   output logic             pkt_done,
   output logic [LW-1:0]    pkt_len,
   output logic [15:0]      pkt_sum,
   output logic             pkt_err,
   output logic [15:0]      pkt_count
);

   typedef enum logic {IDLE, RECV} state_t;

   state_t        state;
   logic [2:0]    bp_ptr;
   logic [LW-1:0] len;
   logic [LW-1:0] len_nxt;
   logic [15:0]   sum;
   logic [15:0]   sum_nxt;
   logic [15:0]   data_ext;
   logic          len_err;
   logic          len_sat;
   logic          len_err_nxt;
   logic          pat_err_nxt;
   logic          accept;

   assign accept = s_axis_tvalid & s_axis_tready;

   always_comb begin
      data_ext                = '0;
      data_ext[WIDTH-1:0]     = s_axis_tdata;
   end

   // Values the accumulators take if the current beat is a non-first beat.
   assign len_sat     = (len == LW'(MAX_LEN));
   assign len_nxt     = len_sat ? len : len + LW'(1);
   assign len_err_nxt = len_err | len_sat;
   assign sum_nxt     = sum + data_ext;

`ifdef AXIS_SINK_PATTERN_CHK_EN
   logic [WIDTH-1:0] expected;
   logic             pat_err;

   assign pat_err_nxt = pat_err | (s_axis_tdata != expected);

   // The expected value advances from itself, not from received data, so one
   // bad beat does not cascade into a shifted reference.
   always_ff @(posedge clk) begin
      if (rst) begin
         expected <= '0;
         pat_err  <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            expected <= s_axis_tdata + WIDTH'(1);
            pat_err  <= 1'b0;
         end else begin
            expected <= expected + WIDTH'(1);
            pat_err  <= s_axis_tlast ? 1'b0 : pat_err_nxt;
         end
      end
   end
`else
   assign pat_err_nxt = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         bp_ptr        <= 3'd0;
         s_axis_tready <= 1'b0;
         len           <= '0;
         sum           <= '0;
         len_err       <= 1'b0;
         pkt_done      <= 1'b0;
         pkt_len       <= '0;
         pkt_sum       <= '0;
         pkt_err       <= 1'b0;
         pkt_count     <= '0;
      end else begin
         pkt_done      <= 1'b0;
         // TREADY depends only on en and the mask slot, never on TVALID.
         s_axis_tready <= en & bp_mask[bp_ptr];
         if (en)
            bp_ptr <= bp_ptr + 3'd1;

         if (accept) begin
            case (state)
               IDLE: begin
                  len     <= LW'(1);
                  sum     <= data_ext;
                  len_err <= 1'b0;
                  if (s_axis_tlast) begin
                     // Single-beat packet completes without leaving IDLE.
                     pkt_len   <= LW'(1);
                     pkt_sum   <= data_ext;
                     pkt_err   <= 1'b0;
                     pkt_done  <= 1'b1;
                     pkt_count <= pkt_count + 16'd1;
                  end else begin
                     state <= RECV;
                  end
               end
               RECV: begin
                  len     <= len_nxt;
                  sum     <= sum_nxt;
                  len_err <= len_err_nxt;
                  if (s_axis_tlast) begin
                     pkt_len   <= len_nxt;
                     pkt_sum   <= sum_nxt;
                     pkt_err   <= len_err_nxt | pat_err_nxt;
                     pkt_done  <= 1'b1;
                     pkt_count <= pkt_count + 16'd1;
                     len_err   <= 1'b0;
                     state     <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
